button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 106 ++++++++++
 tb/tb_button_conditioner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: 2-flop sync, per-button debounce, frame-aligned level/press outputs.
// Define BTN_PRESS_LATCH_EN to latch presses shorter than one frame until the next frame_tick.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned NUM_BTN         = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_stable
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam int unsigned BTN_UP    = 3;
   localparam int unsigned BTN_LEFT  = 2;
   localparam int unsigned BTN_RIGHT = 1;
   localparam int unsigned BTN_DOWN  = 0;

   logic [NUM_BTN-1:0] sync1_q, sync2_q;
   logic [NUM_BTN-1:0] stable_q, stable_d;
   logic [CNT_W-1:0]   cnt_q [NUM_BTN];
   logic [CNT_W-1:0]   cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] frame_raw, frame_res;
   logic [NUM_BTN-1:0] level_q, press_q;

   // Counter restarts whenever the synced level agrees with the debounced one, so it never wraps.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         cnt_q    <= '{default: '0};
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef BTN_PRESS_LATCH_EN
   logic [NUM_BTN-1:0] sticky_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= '0;
      end else if (frame_tick) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= sticky_q | stable_q;
      end
   end

   assign frame_raw = stable_q | sticky_q;
`else
   assign frame_raw = stable_q;
`endif

   // Opposing directions cancel; centre is never masked.
   always_comb begin
      frame_res = frame_raw;
      if (frame_raw[BTN_UP] && frame_raw[BTN_DOWN]) begin
         frame_res[BTN_UP]   = 1'b0;
         frame_res[BTN_DOWN] = 1'b0;
      end
      if (frame_raw[BTN_LEFT] && frame_raw[BTN_RIGHT]) begin
         frame_res[BTN_LEFT]  = 1'b0;
         frame_res[BTN_RIGHT] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= '0;
         press_q <= '0;
      end else if (frame_tick) begin
         level_q <= frame_res;
         press_q <= frame_res & ~level_q;
      end else begin
         press_q <= '0;
      end
   end

   assign btn_level  = level_q;
   assign btn_press  = press_q;
   assign btn_stable = stable_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4; ticks are issued explicitly.
// Expected frame values depend on whether BTN_PRESS_LATCH_EN is defined.
module tb_button_conditioner;

`ifdef BTN_PRESS_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic [4:0] btn_raw = '0;
   logic [4:0] btn_level, btn_press, btn_stable;

   int errors = 0;
   int checks = 0;
   logic [9:0] exp_q [$];

   button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .NUM_BTN        (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .frame_tick(frame_tick),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_press (btn_press),
      .btn_stable(btn_stable)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick(input logic [4:0] lvl, input logic [4:0] prs);
      exp_q.push_back({lvl, prs});
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
   endtask

   function automatic logic [4:0] sel(input logic [4:0] latched, input logic [4:0] plain);
      return LATCH ? latched : plain;
   endfunction

   // Monitor: after every tick edge, pop and compare; btn_press must be 0 on all other cycles.
   initial begin
      logic       seen;
      logic [9:0] e;
      forever begin
         @(posedge clk);
         seen = frame_tick;
         @(negedge clk);
         if (seen) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard: tick with no expected entry at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("tick_level", btn_level, e[9:5]);
               check("tick_press", btn_press, e[4:0]);
            end
         end else begin
            check("idle_press", btn_press, 5'b00000);
         end
      end
   end

   initial begin
      logic [4:0] leftover;
      step(3);
      check("rst_stable", btn_stable, 5'b00000);
      check("rst_level", btn_level, 5'b00000);
      rst = 1'b0;
      step(2);
      tick(5'h00, 5'h00);                          // T1

      // Clean up press
      btn_raw = 5'h08;
      step(5);
      check("up_stable_e5", btn_stable, 5'h00);
      step(1);
      check("up_stable_e6", btn_stable, 5'h08);
      step(3);
      tick(5'h08, 5'h08);                          // T2
      tick(5'h08, 5'h00);                          // T3 back-to-back tick
      btn_raw = 5'h00;
      step(6);
      check("up_release", btn_stable, 5'h00);
      tick(sel(5'h08, 5'h00), 5'h00);              // T4
      tick(5'h00, 5'h00);                          // T5

      // Bouncing right
      btn_raw = 5'h02; step(2);
      check("bounce_a", btn_stable, 5'h00);
      btn_raw = 5'h00; step(2);
      check("bounce_b", btn_stable, 5'h00);
      btn_raw = 5'h02; step(2);
      check("bounce_c", btn_stable, 5'h00);
      btn_raw = 5'h00; step(2);
      check("bounce_d", btn_stable, 5'h00);
      btn_raw = 5'h02; step(5);
      check("bounce_e5", btn_stable, 5'h00);
      step(1);
      check("bounce_e6", btn_stable, 5'h02);
      tick(5'h02, 5'h02);                          // T6

      // Left and right together cancel
      btn_raw = 5'h06;
      step(6);
      check("lr_stable", btn_stable, 5'h06);
      tick(5'h00, 5'h00);                          // T7
      btn_raw = 5'h02;
      step(6);
      tick(sel(5'h00, 5'h02), sel(5'h00, 5'h02));  // T8
      tick(5'h02, sel(5'h02, 5'h00));              // T9
      btn_raw = 5'h00;
      step(6);
      tick(sel(5'h02, 5'h00), 5'h00);              // T10
      tick(5'h00, 5'h00);                          // T11

      // Up and down cancel, centre passes
      btn_raw = 5'h19;
      step(6);
      check("udc_stable", btn_stable, 5'h19);
      tick(5'h10, 5'h10);                          // T12
      btn_raw = 5'h00;
      step(6);
      tick(sel(5'h10, 5'h00), 5'h00);              // T13
      tick(5'h00, 5'h00);                          // T14

      // Short centre pulse between ticks
      btn_raw = 5'h10;
      step(6);
      check("cen_pulse_hi", btn_stable, 5'h10);
      step(3);
      btn_raw = 5'h00;
      step(8);
      check("cen_pulse_lo", btn_stable, 5'h00);
      tick(sel(5'h10, 5'h00), sel(5'h10, 5'h00));  // T15
      tick(5'h00, 5'h00);                          // T16

      // Reset mid-debounce with outputs active
      btn_raw = 5'h10;
      step(6);
      tick(5'h10, 5'h10);                          // T17
      btn_raw = 5'h11;
      step(3);
      #2;
      rst = 1'b1;
      #1;
      check("async_stable", btn_stable, 5'h00);
      check("async_level", btn_level, 5'h00);
      check("async_press", btn_press, 5'h00);
      step(3);
      check("rst_hold_stable", btn_stable, 5'h00);
      rst = 1'b0;
      step(5);
      check("post_rst_e5", btn_stable, 5'h00);
      step(1);
      check("post_rst_e6", btn_stable, 5'h11);
      step(2);
      tick(5'h11, 5'h11);                          // T18
      tick(5'h11, 5'h00);                          // T19
      step(3);

      leftover = 5'(exp_q.size());
      check("queue_drained", leftover, 5'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
